// File: rtl/dt_pkg.sv
// Shared constants and state encoding for the distance-transform datapath.
package dt_pkg;
    localparam int IMG_DIM   = 128;
    localparam int PIX_AW    = 14;
    localparam int WORD_AW   = 10;
    localparam int WORD_BITS = 16;
    localparam int BIT_AW    = PIX_AW - WORD_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/dt_pack.sv
// Rescans the 8-bit result image, thresholds each pixel and packs 16 pixels
// per word into the bit-plane memory, counting foreground pixels on the way.
module dt_pack
    import dt_pkg::*;
#(
    parameter logic [7:0] THR = 8'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 res_rd,
    output logic [PIX_AW-1:0]    res_addr,
    input  logic [7:0]           res_di,
    output logic                 sti_wr,
    output logic [WORD_AW-1:0]   sti_addr,
    output logic [WORD_BITS-1:0] sti_do,
    output logic [PIX_AW:0]      ones_cnt,
    output logic                 done
);

    state_t                 state, state_nxt;
    logic [PIX_AW-1:0]      pix_cnt, pix_nxt;
    logic [WORD_BITS-1:0]   shreg, sh_nxt;
    logic [PIX_AW:0]        ones_nxt;
    logic [BIT_AW-1:0]      bit_idx;
    logic                   pix_bit;

    assign bit_idx  = pix_cnt[BIT_AW-1:0];
    assign pix_bit  = (res_di >= THR);
    // The pixel counter is the address presented during READ.
    assign res_addr = pix_cnt;

    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_cnt;
        sh_nxt    = shreg;
        ones_nxt  = ones_cnt;
        unique case (state)
            IDLE: begin
                state_nxt = READ;
                pix_nxt   = '0;
            end
            READ: begin
                sh_nxt   = {shreg[WORD_BITS-2:0], pix_bit};
                ones_nxt = ones_cnt + {{PIX_AW{1'b0}}, pix_bit};
                // Counter parks on the last pixel of the word so WRITE still sees its word address.
                if (bit_idx == '1) state_nxt = WRITE;
                else               pix_nxt   = pix_cnt + 1'b1;
            end
            WRITE: begin
                pix_nxt   = pix_cnt + 1'b1;
                state_nxt = (pix_cnt == '1) ? FINISH : READ;
            end
            FINISH: state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            shreg    <= '0;
            ones_cnt <= '0;
            res_rd   <= 1'b0;
            sti_wr   <= 1'b0;
            sti_addr <= '0;
            sti_do   <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pix_cnt  <= pix_nxt;
            shreg    <= sh_nxt;
            ones_cnt <= ones_nxt;
            res_rd   <= (state_nxt == READ);
            sti_wr   <= (state_nxt == WRITE);
            done     <= (state_nxt == FINISH);
            if (state_nxt == WRITE) begin
                sti_addr <= pix_nxt[PIX_AW-1:BIT_AW];
                sti_do   <= sh_nxt;
            end
        end
    end

endmodule
